// File: rtl/bnn_xnor_dot_array.sv
// Multi-lane XNOR/popcount BNN dot-product engine with a two-stage pipeline and pad masking.
// Optional per-lane threshold binarisation is enabled by defining BNN_THRESH_EN.
module bnn_xnor_dot_array #(
  parameter int N_BITS  = 256,
  parameter int WORD_W  = 32,
  parameter int N_LANES = 4,
  parameter int ACC_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [WORD_W-1:0]          a_word,
  input  logic [N_LANES*WORD_W-1:0]  w_words,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_LANES*ACC_W-1:0]   acc_out,
  output logic                       len_err
`ifdef BNN_THRESH_EN
  ,
  input  logic [N_LANES*ACC_W-1:0]   thr_in,
  output logic [N_LANES-1:0]         sign_out
`endif
);

  localparam int N_WORDS   = (N_BITS + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = N_BITS - (N_WORDS - 1) * WORD_W;
  localparam int CNT_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int PC_W      = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

  function automatic logic [WORD_W-1:0] last_mask();
    logic [WORD_W-1:0] m;
    for (int i = 0; i < WORD_W; i++) m[i] = (i < LAST_BITS);
    return m;
  endfunction

  localparam logic [WORD_W-1:0] LAST_MASK = last_mask();

  function automatic logic [PC_W-1:0] popcnt(input logic [WORD_W-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < WORD_W; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

  function automatic logic signed [ACC_W-1:0] contrib(input logic [PC_W-1:0] pc, input logic use_last);
    int nb;
    nb = use_last ? LAST_BITS : WORD_W;
    return ACC_W'(2 * int'(pc) - nb);
  endfunction

  // IDLE: waiting for first beat | ACCUM: streaming beats
  // DRAIN: last beat in flight    | HOLD: result presented until handshake
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t                  state_q;
  logic                    in_ready_q, out_valid_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    over_q;
  logic                    s1_vld_q, s1_first_q, s1_last_q, s1_err_q, s1_nbl_q;
  logic [PC_W-1:0]         s1_pc_q [N_LANES];
  logic signed [ACC_W-1:0] acc_q   [N_LANES];
  logic                    err_q;

  logic                    accept, at_last_idx, beat_err, err_d;
  logic [WORD_W-1:0]       mask;
  logic [PC_W-1:0]         pc_d    [N_LANES];
  logic signed [ACC_W-1:0] acc_d   [N_LANES];

  assign accept      = in_valid & in_ready_q;
  assign at_last_idx = (cnt_q == LAST_IDX) & ~over_q;
  assign beat_err    = over_q | (in_last & (cnt_q != LAST_IDX));
  assign mask        = at_last_idx ? LAST_MASK : '1;

  always_comb begin
    for (int k = 0; k < N_LANES; k++) begin
      pc_d[k]  = popcnt(~(a_word ^ w_words[k*WORD_W +: WORD_W]) & mask);
      acc_d[k] = (s1_first_q ? '0 : acc_q[k]) + contrib(s1_pc_q[k], s1_nbl_q);
    end
    err_d = (s1_first_q ? 1'b0 : err_q) | s1_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      over_q      <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_nbl_q    <= 1'b0;
      err_q       <= 1'b0;
      for (int k = 0; k < N_LANES; k++) begin
        s1_pc_q[k] <= '0;
        acc_q[k]   <= '0;
      end
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_first_q <= (state_q == IDLE);
        s1_last_q  <= in_last;
        s1_err_q   <= beat_err;
        s1_nbl_q   <= at_last_idx;
        for (int k = 0; k < N_LANES; k++) s1_pc_q[k] <= pc_d[k];
        if (in_last) begin
          cnt_q  <= '0;
          over_q <= 1'b0;
        end else if (cnt_q == LAST_IDX) begin
          over_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      if (s1_vld_q) begin
        for (int k = 0; k < N_LANES; k++) acc_q[k] <= acc_d[k];
        err_q <= err_d;
      end
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            state_q <= in_last ? DRAIN : ACCUM;
            if (in_last) in_ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (s1_vld_q && s1_last_q) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign len_err   = err_q;

  always_comb begin
    acc_out = '0;
    for (int k = 0; k < N_LANES; k++) acc_out[k*ACC_W +: ACC_W] = acc_q[k];
  end

`ifdef BNN_THRESH_EN
  logic [N_LANES*ACC_W-1:0] thr_q;
  logic [N_LANES-1:0]       sign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q  <= '0;
      sign_q <= '0;
    end else begin
      if (accept && in_last) thr_q <= thr_in;
      if (s1_vld_q && s1_last_q) begin
        for (int k = 0; k < N_LANES; k++)
          sign_q[k] <= (acc_d[k] >= $signed(thr_q[k*ACC_W +: ACC_W]));
      end
    end
  end

  assign sign_out = sign_q;
`endif

endmodule
